// File: rtl/alu_issue_stage.sv
// alu_issue_stage: request FIFO feeding a combinational 4-bit ALU, with the
// ALU result captured into a valid/ready output register.
//
// The head FIFO entry drives the ALU directly. A pop moves the ALU result for
// that head into the output register in the same edge, so an op accepted into
// an empty stage is visible one edge after acceptance. Full is never relieved
// by a same-cycle pop (in_ready depends only on occupancy).

module alu_issue_stage #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_in_valid,
    output logic                     o_in_ready,
    input  logic [3:0]               i_in_a,
    input  logic [3:0]               i_in_b,
    input  logic [2:0]               i_in_opcode,
    output logic [3:0]               o_alu_operand_a,
    output logic [3:0]               o_alu_operand_b,
    output logic [2:0]               o_alu_opcode,
    input  logic [7:0]               i_alu_result,
    output logic                     o_out_valid,
    input  logic                     i_out_ready,
    output logic [7:0]               o_out_result,
    output logic [2:0]               o_out_opcode,
    output logic                     o_out_zero,
    output logic [$clog2(DEPTH):0]   o_fifo_count,
    output logic [CNT_W-1:0]         o_issued_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [3:0]       r_mem_a  [DEPTH];
    logic [3:0]       r_mem_b  [DEPTH];
    logic [2:0]       r_mem_op [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;

    logic             r_out_valid;
    logic [7:0]       r_out_result;
    logic [2:0]       r_out_opcode;
    logic [CNT_W-1:0] r_issued;

    logic             w_empty;
    logic             w_push;
    logic             w_pop;

    assign w_empty    = (r_count == '0);
    assign o_in_ready = (r_count < FULL_CNT);
    assign w_push     = i_in_valid & o_in_ready;
    // Pop whenever there is a head and the output slot is free or draining.
    assign w_pop      = !w_empty & (!r_out_valid | i_out_ready);

    // ALU sees only registered FIFO state; zeros when nothing is queued.
    assign o_alu_operand_a = w_empty ? 4'd0 : r_mem_a[r_rd_ptr];
    assign o_alu_operand_b = w_empty ? 4'd0 : r_mem_b[r_rd_ptr];
    assign o_alu_opcode    = w_empty ? 3'd0 : r_mem_op[r_rd_ptr];

    assign o_out_valid    = r_out_valid;
    assign o_out_result   = r_out_result;
    assign o_out_opcode   = r_out_opcode;
    assign o_out_zero     = (r_out_result == 8'd0);
    assign o_fifo_count   = r_count;
    assign o_issued_count = r_issued;

    // Storage array; stale contents are unreachable once pointers reset.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem_a[r_wr_ptr]  <= i_in_a;
            r_mem_b[r_wr_ptr]  <= i_in_b;
            r_mem_op[r_wr_ptr] <= i_in_opcode;
        end
    end

    // Pointers wrap naturally at DEPTH (power of two); count tracks occupancy.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (PTR_W + 1)'(1);
                2'b01:   r_count <= r_count - (PTR_W + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Output register: capture ALU result on pop, release on consumer transfer.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_out_valid  <= 1'b0;
            r_out_result <= 8'd0;
            r_out_opcode <= 3'd0;
            r_issued     <= '0;
        end else if (w_pop) begin
            r_out_valid  <= 1'b1;
            r_out_result <= i_alu_result;
            r_out_opcode <= r_mem_op[r_rd_ptr];
            r_issued     <= r_issued + CNT_W'(1);
        end else if (r_out_valid && i_out_ready) begin
            r_out_valid  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Testbench for alu_issue_stage: a stand-in for the team ALU closes the loop,
// and a queue-based model of the stage predicts every visible output.

module tb_alu_issue_stage;

    localparam int DEPTH = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       in_valid;
    logic       out_ready;
    logic [3:0] in_a;
    logic [3:0] in_b;
    logic [2:0] in_op;

    logic        in_ready, out_valid, out_zero;
    logic [3:0]  alu_a, alu_b;
    logic [2:0]  alu_op, out_opcode;
    logic [7:0]  alu_result, out_result;
    logic [2:0]  fifo_count;
    logic [15:0] issued_count;

    logic        w_in_ready, w_out_valid, w_out_zero;
    logic [3:0]  w_alu_a, w_alu_b;
    logic [2:0]  w_alu_op, w_out_opcode;
    logic [7:0]  w_alu_result, w_out_result;
    logic [2:0]  w_fifo_count;
    logic [3:0]  w_issued;

    int n_tests = 0;
    int n_fail  = 0;

    // Team ALU behaviour as seen by this stage.
    function automatic logic [7:0] alu_model(input logic [3:0] a, input logic [3:0] b,
                                             input logic [2:0] op);
        logic [7:0] ea, eb;
        ea = {4'b0, a};
        eb = {4'b0, b};
        case (op)
            3'd0:    return ea + eb;
            3'd1:    return ea - eb;
            3'd2:    return ea & eb;
            3'd3:    return ea | eb;
            3'd4:    return ea ^ eb;
            3'd5:    return ea * eb;
            3'd6:    return ~ea;
            default: return {b, a};
        endcase
    endfunction

    assign alu_result   = alu_model(alu_a, alu_b, alu_op);
    assign w_alu_result = alu_model(w_alu_a, w_alu_b, w_alu_op);

    alu_issue_stage #(.DEPTH(DEPTH), .CNT_W(16)) u_dut (
        .i_clk(clk), .i_rst(rst),
        .i_in_valid(in_valid), .o_in_ready(in_ready),
        .i_in_a(in_a), .i_in_b(in_b), .i_in_opcode(in_op),
        .o_alu_operand_a(alu_a), .o_alu_operand_b(alu_b), .o_alu_opcode(alu_op),
        .i_alu_result(alu_result),
        .o_out_valid(out_valid), .i_out_ready(out_ready),
        .o_out_result(out_result), .o_out_opcode(out_opcode), .o_out_zero(out_zero),
        .o_fifo_count(fifo_count), .o_issued_count(issued_count)
    );

    alu_issue_stage #(.DEPTH(DEPTH), .CNT_W(4)) u_dut_w (
        .i_clk(clk), .i_rst(rst),
        .i_in_valid(in_valid), .o_in_ready(w_in_ready),
        .i_in_a(in_a), .i_in_b(in_b), .i_in_opcode(in_op),
        .o_alu_operand_a(w_alu_a), .o_alu_operand_b(w_alu_b), .o_alu_opcode(w_alu_op),
        .i_alu_result(w_alu_result),
        .o_out_valid(w_out_valid), .i_out_ready(out_ready),
        .o_out_result(w_out_result), .o_out_opcode(w_out_opcode), .o_out_zero(w_out_zero),
        .o_fifo_count(w_fifo_count), .o_issued_count(w_issued)
    );

    logic [27:0] dut_core, w_core;
    assign dut_core = {in_ready, out_valid, out_result, out_opcode, out_zero,
                       fifo_count, alu_a, alu_b, alu_op};
    assign w_core   = {w_in_ready, w_out_valid, w_out_result, w_out_opcode, w_out_zero,
                       w_fifo_count, w_alu_a, w_alu_b, w_alu_op};

    // Reference model: queued requests plus the output slot.
    logic [10:0] m_q[$];
    bit          m_ov = 1'b0;
    logic [7:0]  m_res = 8'd0;
    logic [2:0]  m_op = 3'd0;
    int unsigned m_issued = 0;

    function automatic logic [27:0] exp_core();
        logic [10:0] h;
        h = (m_q.size() != 0) ? m_q[0] : 11'd0;
        return {(m_q.size() < DEPTH), m_ov, m_res, m_op, (m_res == 8'd0),
                3'(m_q.size()), h};
    endfunction

    task automatic drive(input bit v, input logic [3:0] a, input logic [3:0] b,
                         input logic [2:0] op);
        in_valid = v;
        in_a     = a;
        in_b     = b;
        in_op    = op;
    endtask

    task automatic drive_rand();
        drive(1'b1, 4'($urandom_range(15, 0)), 4'($urandom_range(15, 0)),
              3'($urandom_range(7, 0)));
    endtask

    // One clock: decide model transfers from pre-edge inputs, then advance.
    task automatic tick();
        bit push, pop;
        logic [10:0] h;
        push = in_valid && (m_q.size() < DEPTH);
        pop  = (m_q.size() != 0) && (!m_ov || out_ready);
        @(posedge clk);
        if (rst) begin
            m_q.delete();
            m_ov = 1'b0;
            m_res = 8'd0;
            m_op = 3'd0;
            m_issued = 0;
        end else begin
            if (pop) begin
                h = m_q.pop_front();
                m_res = alu_model(h[10:7], h[6:3], h[2:0]);
                m_op = h[2:0];
                m_ov = 1'b1;
                m_issued++;
            end else if (m_ov && out_ready) begin
                m_ov = 1'b0;
            end
            if (push) m_q.push_back({in_a, in_b, in_op});
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(1'b0, 4'd0, 4'd0, 3'd0);
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        out_ready = 1'b0;
        drive(1'b0, 4'd0, 4'd0, 3'd0);
        tick();
        tick();
        rst = 1'b0;
        n_tests++;
        if ({out_valid, fifo_count, issued_count, out_result, out_opcode, out_zero, in_ready} !==
            {1'b0, 3'd0, 16'd0, 8'd0, 3'd0, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_outputs: got v=%0b cnt=%0d iss=%0d res=%h op=%0d z=%0b rdy=%0b want 0 0 0 00 0 1 1",
                     out_valid, fifo_count, issued_count, out_result, out_opcode, out_zero, in_ready);
        end
        n_tests++;
        if ({alu_a, alu_b, alu_op, w_issued} !== 15'd0) begin
            n_fail++;
            $display("FAIL reset_alu_zero: got a=%0d b=%0d op=%0d wiss=%0d want all 0",
                     alu_a, alu_b, alu_op, w_issued);
        end
    endtask

    task automatic test_single();
        out_ready = 1'b1;
        drive(1'b1, 4'd3, 4'd5, 3'd0);
        tick();
        drive(1'b0, 4'd0, 4'd0, 3'd0);
        n_tests++;
        if ({out_valid, fifo_count, alu_a, alu_b, alu_op} !== {1'b0, 3'd1, 4'd3, 4'd5, 3'd0}) begin
            n_fail++;
            $display("FAIL single_queued: got v=%0b cnt=%0d alu=%0d,%0d,%0d want 0 1 3,5,0",
                     out_valid, fifo_count, alu_a, alu_b, alu_op);
        end
        tick();
        n_tests++;
        if ({out_valid, out_result, out_opcode, out_zero, issued_count} !==
            {1'b1, 8'h08, 3'd0, 1'b0, 16'd1}) begin
            n_fail++;
            $display("FAIL single_result: got v=%0b res=%h op=%0d z=%0b iss=%0d want 1 08 0 0 1",
                     out_valid, out_result, out_opcode, out_zero, issued_count);
        end
        tick();
        n_tests++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_drain: got out_valid=%0b want 0", out_valid);
        end
    endtask

    task automatic test_sweep();
        logic [3:0] sa[4] = '{4'd2, 4'd15, 4'd5, 4'd6};
        logic [3:0] sb[4] = '{4'd5, 4'd15, 4'd0, 4'd6};
        logic [2:0] so[4] = '{3'd1, 3'd5, 3'd6, 3'd4};
        logic [7:0] se[4] = '{8'hFD, 8'hE1, 8'hFA, 8'h00};
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i < 4) drive(1'b1, sa[i], sb[i], so[i]);
            else       drive(1'b0, 4'd0, 4'd0, 3'd0);
            tick();
            if (i >= 1) begin
                n_tests++;
                if ({out_valid, out_result, out_opcode, out_zero} !==
                    {1'b1, se[i-1], so[i-1], (se[i-1] == 8'h00)}) begin
                    n_fail++;
                    $display("FAIL sweep_%0d: got v=%0b res=%h op=%0d z=%0b want 1 %h %0d %0b",
                             i - 1, out_valid, out_result, out_opcode, out_zero,
                             se[i-1], so[i-1], (se[i-1] == 8'h00));
                end
            end
        end
        tick();
        n_tests++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL sweep_drain: got out_valid=%0b want 0", out_valid);
        end
    endtask

    task automatic test_backpressure();
        logic [10:0] reqs[6];
        int acc;
        logic [7:0] first_res;
        do_reset();
        out_ready = 1'b0;
        acc = 0;
        for (int i = 0; i < 6; i++) begin
            drive_rand();
            reqs[i] = {in_a, in_b, in_op};
            if (in_ready) acc++;
            tick();
        end
        drive(1'b0, 4'd0, 4'd0, 3'd0);
        first_res = alu_model(reqs[0][10:7], reqs[0][6:3], reqs[0][2:0]);
        n_tests++;
        if (acc !== 5 || in_ready !== 1'b0 || fifo_count !== 3'd4) begin
            n_fail++;
            $display("FAIL bp_full: got accepted=%0d rdy=%0b cnt=%0d want 5 0 4", acc, in_ready, fifo_count);
        end
        for (int i = 0; i < 3; i++) begin
            n_tests++;
            if ({out_valid, out_result} !== {1'b1, first_res}) begin
                n_fail++;
                $display("FAIL bp_hold_%0d: got v=%0b res=%h want 1 %h", i, out_valid, out_result, first_res);
            end
            tick();
        end
        out_ready = 1'b1;
        for (int j = 1; j < 5; j++) begin
            tick();
            n_tests++;
            if ({out_valid, out_result, out_opcode} !==
                {1'b1, alu_model(reqs[j][10:7], reqs[j][6:3], reqs[j][2:0]), reqs[j][2:0]}) begin
                n_fail++;
                $display("FAIL bp_drain_%0d: got v=%0b res=%h op=%0d want 1 %h %0d", j, out_valid,
                         out_result, out_opcode, alu_model(reqs[j][10:7], reqs[j][6:3], reqs[j][2:0]),
                         reqs[j][2:0]);
            end
        end
        tick();
        n_tests++;
        if (out_valid !== 1'b0 || fifo_count !== 3'd0) begin
            n_fail++;
            $display("FAIL bp_empty: got v=%0b cnt=%0d want 0 0", out_valid, fifo_count);
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive_rand();
            tick();
        end
        n_tests++;
        if ({fifo_count, out_valid} !== {3'd3, 1'b1}) begin
            n_fail++;
            $display("FAIL simul_setup: got cnt=%0d v=%0b want 3 1", fifo_count, out_valid);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive_rand();
            tick();
            n_tests++;
            if (fifo_count !== 3'd3 || dut_core !== exp_core()) begin
                n_fail++;
                $display("FAIL simul_steady_%0d: got cnt=%0d core=%h want 3 %h", i, fifo_count,
                         dut_core, exp_core());
            end
        end
        out_ready = 1'b0;
        drive_rand();
        tick();
        drive_rand();
        out_ready = 1'b1;
        n_tests++;
        if ({fifo_count, in_ready} !== {3'd4, 1'b0}) begin
            n_fail++;
            $display("FAIL simul_full_no_wt: got cnt=%0d rdy=%0b want 4 0", fifo_count, in_ready);
        end
        tick();
        n_tests++;
        if (fifo_count !== 3'd3) begin
            n_fail++;
            $display("FAIL simul_pop_only: got cnt=%0d want 3", fifo_count);
        end
        drive(1'b0, 4'd0, 4'd0, 3'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            n_tests++;
            if (dut_core !== exp_core()) begin
                n_fail++;
                $display("FAIL simul_drain_%0d: got %h want %h", i, dut_core, exp_core());
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive_rand();
            tick();
        end
        rst = 1'b1;
        out_ready = 1'b1;
        drive_rand();
        tick();
        rst = 1'b0;
        drive(1'b0, 4'd0, 4'd0, 3'd0);
        n_tests++;
        if ({fifo_count, out_valid, issued_count, alu_a, alu_b, alu_op} !== 34'd0) begin
            n_fail++;
            $display("FAIL rstmid_clear: got cnt=%0d v=%0b iss=%0d alu=%0d,%0d,%0d want all 0",
                     fifo_count, out_valid, issued_count, alu_a, alu_b, alu_op);
        end
        drive(1'b1, 4'd9, 4'd4, 3'd1);
        tick();
        drive(1'b0, 4'd0, 4'd0, 3'd0);
        n_tests++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_early: got out_valid=%0b want 0", out_valid);
        end
        tick();
        n_tests++;
        if ({out_valid, out_result, out_opcode, issued_count} !== {1'b1, 8'h05, 3'd1, 16'd1}) begin
            n_fail++;
            $display("FAIL rstmid_fresh: got v=%0b res=%h op=%0d iss=%0d want 1 05 1 1",
                     out_valid, out_result, out_opcode, issued_count);
        end
        tick();
    endtask

    task automatic test_wrap();
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 17; i++) begin
            drive_rand();
            tick();
        end
        drive(1'b0, 4'd0, 4'd0, 3'd0);
        tick();
        n_tests++;
        if (w_issued !== 4'd1 || issued_count !== 16'd17) begin
            n_fail++;
            $display("FAIL wrap: got w_issued=%0d issued=%0d want 1 17", w_issued, issued_count);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(3, 0) != 0) drive_rand();
            else drive(1'b0, 4'd0, 4'd0, 3'd0);
            out_ready = ($urandom_range(2, 0) != 0);
            tick();
            n_tests++;
            if ({dut_core, issued_count} !== {exp_core(), 16'(m_issued)}) begin
                n_fail++;
                $display("FAIL random_%0d: got %h/%0d want %h/%0d", i, dut_core, issued_count,
                         exp_core(), 16'(m_issued));
            end
            n_tests++;
            if ({w_core, w_issued} !== {exp_core(), 4'(m_issued)}) begin
                n_fail++;
                $display("FAIL random_w_%0d: got %h/%0d want %h/%0d", i, w_core, w_issued,
                         exp_core(), 4'(m_issued));
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        out_ready = 1'b0;
        drive(1'b0, 4'd0, 4'd0, 3'd0);
        #1;
        test_reset();
        test_single();
        test_sweep();
        test_backpressure();
        test_simultaneous();
        test_reset_mid();
        test_wrap();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Upstream feeder for the team's 4-bit combinational ALU (operand_a[3:0], operand_b[3:0], opcode[2:0] -> result[7:0]).
- Buffers incoming operation requests in a small FIFO and presents the head entry to the ALU.
- Captures the ALU result into a registered output with valid/ready handshake; the ALU sits combinationally between the head entry and the result register.

Parameters:
- DEPTH, 4, request FIFO depth in entries; power of 2, minimum 2.
- CNT_W, 16, width of the wrapping issued-operation counter.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  request valid.
- in_ready  out  1  request accepted when in_valid & in_ready at clk edge.
- in_a  in  4  operand A of request.
- in_b  in  4  operand B of request.
- in_opcode  in  3  ALU opcode of request.
- alu_operand_a  out  4  to ALU operand_a.
- alu_operand_b  out  4  to ALU operand_b.
- alu_opcode  out  3  to ALU opcode.
- alu_result  in  8  from ALU result (combinational).
- out_valid  out  1  registered result valid.
- out_ready  in  1  consumer ready.
- out_result  out  8  captured ALU result.
- out_opcode  out  3  opcode that produced out_result.
- out_zero  out  1  high when out_result == 0.
- fifo_count  out  $clog2(DEPTH)+1  current FIFO occupancy.
- issued_count  out  CNT_W  operations moved into the output register; wraps to 0 after all-ones.

Behaviour:
- Reset, synchronous, takes priority over all other activity:
  - FIFO pointers and fifo_count = 0.
  - out_valid = 0; out_result, out_opcode and issued_count = 0; out_zero = 1.
  - All FIFO contents and any held result are discarded, including in-flight entries.
- in_ready = (fifo_count < DEPTH).
  - No write-through when full: a simultaneous pop does not raise in_ready in that same cycle.
- push = in_valid & in_ready. Writes {in_a, in_b, in_opcode} at the tail.
- ALU drive:
  - When the FIFO is non-empty, the alu_* outputs equal the head entry.
  - When the FIFO is empty, the alu_* outputs are all zero.
  - alu_* are combinational from registered FIFO state; there is no path from in_* to alu_*.
- pop = (fifo_count != 0) & (!out_valid | out_ready).
  - On pop at an edge: out_result <= alu_result, out_opcode <= head opcode, out_valid <= 1, head pointer advances, issued_count increments.
- If out_valid & out_ready & !pop at an edge, out_valid <= 0.
  - out_result and out_opcode hold their last values.
- out_valid = 1 with out_ready = 0: out_result, out_opcode and out_zero stay stable until the transfer.
- out_zero is combinational from out_result.
- fifo_count update:
  - +1 on push only.
  - -1 on pop only.
  - Unchanged on push and pop in the same cycle.
- Latency:
  - A request accepted at edge k into an empty FIFO with an empty or draining output appears with out_valid high after edge k+1.
  - Sustained throughput is 1 op/cycle while out_ready = 1.
- Ordering: results leave strictly in acceptance order; nothing is dropped or duplicated.
- Capacity: DEPTH FIFO entries plus 1 output register.
- Pointers wrap modulo DEPTH.
- alu_result is sampled only on pop edges; its value in other cycles is ignored.

Test Plan:
The bench connects this block to the team ALU.
- Single op: push a=3, b=5, op=000 at edge 0 -> out_valid high after edge 1, out_result=0x08, out_opcode=000, out_zero=0, issued_count=1.
- Arithmetic sweep, out_ready=1, each result in order one cycle apart:
  - a=2, b=5, op=001 -> 0xFD.
  - a=15, b=15, op=101 -> 0xE1.
  - a=5, op=110 -> 0xFA.
  - a=6, b=6, op=100 -> 0x00 with out_zero=1.
- Backpressure: out_ready=0, offer 6 back-to-back requests (DEPTH=4):
  - Exactly 5 are accepted, then in_ready=0 and fifo_count=4; out_result holds the first result stable.
  - Raise out_ready -> remaining 4 results drain in order on consecutive cycles, then out_valid drops.
- Simultaneous push/pop:
  - At fifo_count=3 with out_ready=1 and in_valid=1 -> fifo_count stays 3 across 10 cycles.
  - At fifo_count=4 -> in_ready=0 even while popping.
- Reset mid-stream: with fifo_count=3 and out_valid=1, assert rst for one edge:
  - Next cycle: fifo_count=0, out_valid=0, issued_count=0, alu_*=0.
  - A fresh push then returns its correct result with 2-edge latency.
- Counter wrap: with CNT_W=4, issue 17 ops -> issued_count reads 1.
